// File: rtl/serial_addsub_if.sv
// Operand/result bundle for the digit-serial adder/subtractor.
// The master drives start/op/a/b; the slave returns the registered result, flags and status.
interface serial_addsub_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic             op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             overflow;
  logic             zero;
  logic             busy;
  logic             done;

  modport master (
    output start, op, a, b,
    input  sum, cout, overflow, zero, busy, done
  );

  modport slave (
    input  start, op, a, b,
    output sum, cout, overflow, zero, busy, done
  );
endinterface

// File: rtl/serial_addsub.sv
// Digit-serial adder/subtractor: CHUNK bits per cycle, carry held between cycles, N = WIDTH/CHUNK cycles.
// Optional signed saturation of the result on overflow when SERIAL_ADDSUB_SAT_EN is defined.
//   state | meaning
//   IDLE  | waiting for start; result outputs hold the last completion
//   RUN   | processing chunk idx_q; finishes on chunk N-1
module serial_addsub #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic           clk,
  input  logic           rst,
  serial_addsub_if.slave bus
);
  localparam int N  = WIDTH / CHUNK;
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] psum_q, psum_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic             zero_q, zero_d;
  logic             done_q, done_d;

  logic [CHUNK-1:0] a_k, b_k;
  logic [CHUNK:0]   chunk_sum;
  logic [WIDTH-1:0] merged;
  logic [WIDTH-1:0] result;
  logic             raw_ovf;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      psum_q  <= '0;
      sum_q   <= '0;
      idx_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      psum_q  <= psum_d;
      sum_q   <= sum_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      zero_q  <= zero_d;
      done_q  <= done_d;
    end
  end

  // Datapath for the current chunk; merged is the partial sum with this chunk filled in.
  always_comb begin
    a_k       = a_q[idx_q*CHUNK +: CHUNK];
    b_k       = b_q[idx_q*CHUNK +: CHUNK];
    chunk_sum = {1'b0, a_k} + {1'b0, b_k} + (CHUNK+1)'(carry_q);
    merged    = psum_q;
    merged[idx_q*CHUNK +: CHUNK] = chunk_sum[CHUNK-1:0];
    raw_ovf   = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (merged[WIDTH-1] != a_q[WIDTH-1]);
    result    = merged;
`ifdef SERIAL_ADDSUB_SAT_EN
    if (raw_ovf) begin
      result = a_q[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end
`endif
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    psum_d  = psum_q;
    sum_d   = sum_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    zero_d  = zero_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          // Subtraction is a + ~b + 1: invert b here and seed the carry with op.
          a_d     = bus.a;
          b_d     = bus.b ^ {WIDTH{bus.op}};
          carry_d = bus.op;
          idx_d   = '0;
          psum_d  = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        psum_d  = merged;
        carry_d = chunk_sum[CHUNK];
        if (idx_q == IW'(N-1)) begin
          state_d = IDLE;
          idx_d   = '0;
          sum_d   = result;
          cout_d  = chunk_sum[CHUNK];
          ovf_d   = raw_ovf;
          zero_d  = (result == '0);
          done_d  = 1'b1;
        end else begin
          idx_d = idx_q + IW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.sum      = sum_q;
  assign bus.cout     = cout_q;
  assign bus.overflow = ovf_q;
  assign bus.zero     = zero_q;
  assign bus.busy     = (state_q == RUN);
  assign bus.done     = done_q;
endmodule

// File: tb/tb_serial_addsub.sv
// Scoreboard bench for serial_addsub at N=1, N=4 and N=32 (WIDTH=32), honouring SERIAL_ADDSUB_SAT_EN.
module tb_serial_addsub;
  typedef struct packed {
    logic [31:0] sum;
    logic        cout;
    logic        ovf;
    logic        zero;
  } exp_t;

`ifdef SERIAL_ADDSUB_SAT_EN
  localparam logic [31:0] OVF_SUM = 32'h7FFF_FFFF;
`else
  localparam logic [31:0] OVF_SUM = 32'h8000_0000;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  serial_addsub_if #(.WIDTH(32)) if_n1  ();
  serial_addsub_if #(.WIDTH(32)) if_n4  ();
  serial_addsub_if #(.WIDTH(32)) if_n32 ();

  serial_addsub #(.WIDTH(32), .CHUNK(32)) dut_n1  (.clk(clk), .rst(rst), .bus(if_n1));
  serial_addsub #(.WIDTH(32), .CHUNK(8))  dut_n4  (.clk(clk), .rst(rst), .bus(if_n4));
  serial_addsub #(.WIDTH(32), .CHUNK(1))  dut_n32 (.clk(clk), .rst(rst), .bus(if_n32));

  int   total  = 0;
  int   passed = 0;
  exp_t q_n1[$];
  exp_t q_n4[$];
  exp_t q_n32[$];

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  // Reference: plain integer arithmetic on unsigned and signed views of the operands.
  function automatic exp_t model(input logic op, input logic [31:0] a, input logic [31:0] b);
    exp_t   e;
    longint ua, ub, sa, sb, ur, sr;
    ua = longint'(a);
    ub = longint'(b);
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ur = op ? (ua - ub) : (ua + ub);
    sr = op ? (sa - sb) : (sa + sb);
    e.cout = op ? (ua >= ub) : (ur >= 64'sh1_0000_0000);
    e.ovf  = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
    e.sum  = ur[31:0];
`ifdef SERIAL_ADDSUB_SAT_EN
    if (e.ovf) e.sum = (sr > 0) ? 32'h7FFF_FFFF : 32'h8000_0000;
`endif
    e.zero = (e.sum == 32'h0);
    return e;
  endfunction

  always @(negedge clk) begin : mon_n1
    exp_t e;
    if (!rst && if_n1.done) begin
      check("n1 expected-done", 64'(q_n1.size() > 0), 64'd1);
      if (q_n1.size() > 0) begin
        e = q_n1.pop_front();
        check("n1 result", 64'({if_n1.sum, if_n1.cout, if_n1.overflow, if_n1.zero}), 64'(e));
      end
    end
  end

  always @(negedge clk) begin : mon_n4
    exp_t e;
    if (!rst && if_n4.done) begin
      check("n4 expected-done", 64'(q_n4.size() > 0), 64'd1);
      if (q_n4.size() > 0) begin
        e = q_n4.pop_front();
        check("n4 result", 64'({if_n4.sum, if_n4.cout, if_n4.overflow, if_n4.zero}), 64'(e));
      end
    end
  end

  always @(negedge clk) begin : mon_n32
    exp_t e;
    if (!rst && if_n32.done) begin
      check("n32 expected-done", 64'(q_n32.size() > 0), 64'd1);
      if (q_n32.size() > 0) begin
        e = q_n32.pop_front();
        check("n32 result", 64'({if_n32.sum, if_n32.cout, if_n32.overflow, if_n32.zero}), 64'(e));
      end
    end
  end

  // Issue on the N=4 unit (called at posedge+1 with it idle); returns edges to done and busy samples.
  task automatic do_op(input logic op, input logic [31:0] a, input logic [31:0] b,
                       output int lat, output int bcnt);
    if_n4.start = 1'b1; if_n4.op = op; if_n4.a = a; if_n4.b = b;
    @(posedge clk); #1;
    if_n4.start = 1'b0;
    q_n4.push_back(model(op, a, b));
    if_n4.a = $urandom; if_n4.b = $urandom; if_n4.op = ~op;
    lat  = 0;
    bcnt = if_n4.busy ? 1 : 0;
    while (!if_n4.done && lat < 40) begin
      @(posedge clk); #1;
      lat++;
      if (if_n4.busy) bcnt++;
    end
  endtask

  function automatic logic [37:0] outs4();
    return {if_n4.busy, if_n4.done, if_n4.cout, if_n4.overflow, if_n4.zero, if_n4.sum};
  endfunction

  initial begin : watchdog
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int lat, bcnt, dc, w;
    logic        op;
    logic [31:0] a, b;
    if_n1.start = 0;  if_n1.op = 0;  if_n1.a = 0;  if_n1.b = 0;
    if_n4.start = 0;  if_n4.op = 0;  if_n4.a = 0;  if_n4.b = 0;
    if_n32.start = 0; if_n32.op = 0; if_n32.a = 0; if_n32.b = 0;

    #12;
    check("reset n1", 64'({if_n1.busy, if_n1.done, if_n1.cout, if_n1.overflow, if_n1.zero, if_n1.sum}), 64'd0);
    check("reset n4", 64'(outs4()), 64'd0);
    check("reset n32", 64'({if_n32.busy, if_n32.done, if_n32.cout, if_n32.overflow, if_n32.zero, if_n32.sum}), 64'd0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;

    do_op(1'b0, 32'hFFFF_FFFF, 32'h0000_0001, lat, bcnt);
    check("add latency", 64'(lat), 64'd4);
    check("add busy cycles", 64'(bcnt), 64'd4);
    check("add wrap flags", 64'({if_n4.sum, if_n4.cout, if_n4.overflow, if_n4.zero}), {29'd0, 32'h0, 3'b101});

    do_op(1'b1, 32'd5, 32'd7, lat, bcnt);
    check("sub borrow", 64'({if_n4.sum, if_n4.cout, if_n4.overflow, if_n4.zero}), {29'd0, 32'hFFFF_FFFE, 3'b000});
    do_op(1'b1, 32'd7, 32'd5, lat, bcnt);
    check("sub no borrow", 64'({if_n4.sum, if_n4.cout, if_n4.overflow, if_n4.zero}), {29'd0, 32'd2, 3'b100});

    // Overflow case with a stray start two cycles into the run.
    if_n4.start = 1'b1; if_n4.op = 1'b0; if_n4.a = 32'h7FFF_FFFF; if_n4.b = 32'h1;
    @(posedge clk); #1;
    if_n4.start = 1'b0;
    q_n4.push_back(model(1'b0, 32'h7FFF_FFFF, 32'h1));
    @(posedge clk); #1;
    @(posedge clk); #1;
    if_n4.start = 1'b1; if_n4.op = 1'b1; if_n4.a = 32'h1111; if_n4.b = 32'h2222;
    @(posedge clk); #1;
    if_n4.start = 1'b0;
    lat = 3;
    while (!if_n4.done && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    check("ignored start latency", 64'(lat), 64'd4);
    check("overflow result", 64'({if_n4.sum, if_n4.overflow}), 64'({OVF_SUM, 1'b1}));

    // Start held through the done cycle: accepted back-to-back.
    if_n4.start = 1'b1; if_n4.op = 1'b0; if_n4.a = 32'd100; if_n4.b = 32'd23;
    @(posedge clk); #1;
    if_n4.start = 1'b0;
    q_n4.push_back(model(1'b0, 32'd100, 32'd23));
    check("done pulse width", 64'(if_n4.done), 64'd0);
    lat = 1;
    while (!if_n4.done && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    check("back-to-back done spacing", 64'(lat), 64'd5);

    // Asynchronous reset in the middle of a run.
    if_n4.start = 1'b1; if_n4.op = 1'b0; if_n4.a = 32'hDEAD_BEEF; if_n4.b = 32'h1;
    @(posedge clk); #1;
    if_n4.start = 1'b0;
    q_n4.push_back(model(1'b0, 32'hDEAD_BEEF, 32'h1));
    @(posedge clk); #1;
    @(posedge clk); #1;
    #2 rst = 1'b1;
    #1;
    check("async reset outputs", 64'(outs4()), 64'd0);
    void'(q_n4.pop_back());
    @(negedge clk); rst = 1'b0;
    dc = 0;
    repeat (10) begin
      @(posedge clk); #1;
      if (if_n4.done) dc++;
    end
    check("no done after reset", 64'(dc), 64'd0);
    do_op(1'b0, 32'h1234_5678, 32'h1111_1111, lat, bcnt);
    check("post-reset add", 64'(if_n4.sum), 64'h2345_6789);

    for (int i = 0; i < 1000; i++) begin
      op = 1'($urandom);
      a  = $urandom;
      b  = $urandom;
      case (i % 16)
        0: b = a;
        1: a = 32'h7FFF_FFFF;
        2: a = 32'h8000_0000;
        3: b = 32'hFFFF_FFFF;
        default: ;
      endcase
      if_n1.start = 1;  if_n1.op = op;  if_n1.a = a;  if_n1.b = b;
      if_n4.start = 1;  if_n4.op = op;  if_n4.a = a;  if_n4.b = b;
      if_n32.start = 1; if_n32.op = op; if_n32.a = a; if_n32.b = b;
      @(posedge clk); #1;
      if_n1.start = 0; if_n4.start = 0; if_n32.start = 0;
      q_n1.push_back(model(op, a, b));
      q_n4.push_back(model(op, a, b));
      q_n32.push_back(model(op, a, b));
      w = 0;
      while ((q_n1.size() + q_n4.size() + q_n32.size()) != 0 && w < 100) begin
        @(posedge clk); #1;
        w++;
      end
      if (w >= 100) begin
        check("sweep drain", 64'(q_n1.size() + q_n4.size() + q_n32.size()), 64'd0);
        q_n1.delete(); q_n4.delete(); q_n32.delete();
      end
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/serial_addsub.md
Name: serial_addsub

Overview:
- Parametrised, multi-cycle digit-serial adder/subtractor. Successor to the fixed 8-bit ripple adder.
- Processes CHUNK bits per clock through a CHUNK-wide full-adder chain, with the carry held in a register between cycles.
- Adds subtraction, a start/done handshake, and carry/overflow/zero flags.
- Sits in the ALU datapath wherever wide operands make a single-cycle ripple chain too slow.

Parameters:
- WIDTH, 32: operand and result width in bits. Must be ≥ 2.
- CHUNK, 8: bits processed per cycle. Must divide WIDTH exactly.
- N = WIDTH/CHUNK is derived, not settable. N must be ≥ 1.

Ports:
- clk  input  1  system clock, rising-edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request a new operation. Sampled only while idle.
- op  input  1  0 = add (a+b), 1 = subtract (a−b).
- a  input  WIDTH  operand A. Latched on accepted start.
- b  input  WIDTH  operand B. Latched on accepted start.
- sum  output  WIDTH  result. Registered, held until the next completion.
- cout  output  1  carry out of the MSB. For subtract, 1 = no borrow (a ≥ b unsigned).
- overflow  output  1  signed two's-complement overflow.
- zero  output  1  1 when sum == 0.
- busy  output  1  operation in progress.
- done  output  1  one-cycle pulse; result outputs are valid from this cycle onward.

Behaviour:
- Reset (async assert, any state):
  - state = IDLE.
  - busy, done, sum, cout, overflow, zero all 0. zero is 0 at reset (no result yet).
  - Internal operand, partial-sum and carry registers are cleared.
  - An operation in flight is abandoned silently; no done pulse follows.
- States:
  - IDLE → RUN on a rising edge with start = 1.
  - RUN → IDLE after the edge that processes chunk N−1.
- Accept (IDLE, start = 1, edge E0):
  - Latch a, and latch b XOR {WIDTH{op}}.
  - Carry register = op.
  - Chunk index = 0; busy = 1 after E0.
- RUN, each edge E1..EN:
  - Chunk k = bits [k·CHUNK +: CHUNK].
  - Compute a_k + b'_k + carry.
  - Store the CHUNK-bit result into the internal partial-sum at chunk k; update carry; increment k.
- Completion (edge EN):
  - Write the full result to sum.
  - cout = final carry.
  - overflow = (a[W−1] == b'[W−1]) && (sum[W−1] != a[W−1]).
  - zero = (result == 0).
  - done = 1 for exactly one cycle; busy = 0; state = IDLE.
- Latency: done is high in the cycle after edge EN, i.e. N cycles after start is accepted. With N = 1 the operation completes in one cycle.
- Handshake:
  - start while busy = 1 is ignored; it is not queued.
  - start asserted during the done cycle is accepted at the next edge, giving back-to-back throughput of one result per N+1 cycles.
  - a, b and op may change freely after acceptance.
- Output stability: sum and the flags change only at completion (or reset). Partial results are never visible.
- Wrap-around: results are modulo 2^WIDTH. The carry beyond the MSB appears only on cout.

Optional Feature:
- Macro: SERIAL_ADDSUB_SAT_EN.
- Defined:
  - On completion with overflow = 1, sum is clamped to signed saturation: 0x7F…F if a[W−1] == 0, else 0x80…0.
  - overflow still reports 1; cout is unchanged (raw carry).
  - zero is computed on the clamped value.
- Undefined: sum is the raw wrapped result. No saturation logic is present.

Test Plan (WIDTH=32, CHUNK=8, N=4):
- Reset, then add a=0xFFFFFFFF, b=0x00000001 → done 4 cycles after accept; sum=0x00000000, cout=1, zero=1, overflow=0. busy is high for exactly 4 cycles.
- Subtract a=0x00000005, b=0x00000007 → sum=0xFFFFFFFE, cout=0 (borrow), overflow=0, zero=0. Subtract a=7, b=5 → sum=2, cout=1.
- Add a=0x7FFFFFFF, b=0x00000001 → overflow=1.
  - Without the macro: sum=0x80000000.
  - With SERIAL_ADDSUB_SAT_EN: sum=0x7FFFFFFF.
- Pulse start again 2 cycles after accept with different operands → ignored; first result delivered unchanged. Start held during the done cycle → second operation accepted, its done arrives 5 cycles after the first done.
- Assert rst at cycle 2 of RUN → busy=0 and all outputs 0 immediately (asynchronous); no done pulse. A fresh operation afterwards (0x12345678 + 0x11111111) gives sum=0x23456789.
- Run a random sweep of 1000 operand/op pairs against a reference model for sum, cout, overflow and zero. Repeat with CHUNK=32 (N=1) and CHUNK=1 (N=32).
